local_memory_arbiter: RTL
=========================

# local_memory_arbiter

Parametrised dual-client arbiter between a core-side primary port and a bus-side secondary port, and a banked set of 1RW+1R SRAM macros. It succeeds the fixed two-bank local memory interface with these changes:
- generic word width and power-of-two bank count;
- per-bank RW address/data buses, so a primary write and a secondary access to different banks complete in parallel;
- round-robin arbitration when both clients target the same bank.

It sits between the core load/store unit and the wishbone slave on one side and the SRAM macros on the other.

## Interface
- ADDRESS_SIZE, 24, client byte-address width.
- WORD_SIZE, 32, data width in bits. Multiple of 8. BYTES = WORD_SIZE/8 (power of two); OFS = log2(BYTES).
- SRAM_ADDRESS_SIZE, 9, word-address width of one macro.
- BLOCK_ADDRESS_SIZE, 2, bank-select bits. BC = 2^BLOCK_ADDRESS_SIZE; 0 is legal (BC = 1).
- clk  in  1  clock; clk0/clk1 are driven directly from it.
- rst  in  1  reset, synchronous, active-high.
- pAddress / sAddress  in  ADDRESS_SIZE  primary / secondary byte address.
- pByteSelect / sByteSelect  in  BYTES  byte enables.
- pEnable / sEnable  in  1  request valid; held until completion.
- pWriteEnable / sWriteEnable  in  1  1 = write, 0 = read.
- pDataWrite / sDataWrite  in  WORD_SIZE  write data.
- pDataRead / sDataRead  out  WORD_SIZE  read data, valid in the completion cycle.
- pBusy / sBusy  out  1  request pending, not yet complete.
- clk0, clk1  out  1  SRAM port clocks.
- csb0  out  BC  per-bank RW chip select, active low.
- web0  out  BC  per-bank write enable, active low.
- wmask0  out  BC*BYTES  per-bank write mask.
- addr0  out  BC*SRAM_ADDRESS_SIZE  per-bank RW address.
- din0  out  BC*WORD_SIZE  per-bank write data.
- dout0  in  BC*WORD_SIZE  per-bank RW read data.
- csb1  out  BC  per-bank R chip select, active low.
- addr1  out  SRAM_ADDRESS_SIZE  shared R address.
- dout1  in  BC*WORD_SIZE  per-bank R read data.

## Operation
- **Decode.** Word index = addr[SRAM_ADDRESS_SIZE+BLOCK_ADDRESS_SIZE+OFS-1:OFS]. Bank = upper BLOCK_ADDRESS_SIZE bits of the index; SRAM word = lower bits.
  - valid = enable && (all address bits above the index are 0).
  - An invalid request is ignored: busy 0, no SRAM activity.
- **Port routing.**
  - Primary reads always use the R port of their bank. They never contend.
  - Primary writes and all secondary accesses contend for the RW port of the target bank.
- **Done flags.** pDone and sDone are registered. Each is set at the posedge that ends a cycle in which that client's access was issued to an SRAM, and cleared on the following posedge.
  - A client with its done flag set is not eligible for issue that cycle, so one request never issues twice.
- **Issue (combinational, per bank b).**
  - Primary write is eligible if valid, pWriteEnable, bank == b, and !pDone.
  - Secondary is eligible if valid, bank == b, and !sDone.
  - If exactly one is eligible, it wins. If both are eligible, the winner is the client that did not win the last conflict.
  - A 1-bit lastWinner register updates only on a conflict. Its reset value is SECONDARY, so primary wins the first conflict.
- **SRAM drive.** The granted bank gets csb0[b]=0, web0[b]=!write, and the client's address, mask and data. Bank b fields sit at slice [b*W +: W].
  - Ungranted banks: csb0=1, web0=1, wmask0=0, addr0=0, din0=0.
  - Primary read: csb1[bank]=0, addr1 = SRAM word; other csb1 bits are 1.
- **Busy.** busy = valid && !done.
- **Read data.** At issue, the client registers its bank index and byte select.
  - During its done cycle, each selected byte = the matching byte of dout (R or RW port) from the registered bank. Unselected bytes = 0xFF.
  - Outside the done cycle, read data = all ones. Write completions also return this masked pattern; it is meaningless for writes.
- **Hazards.** There is no write-to-read forwarding. A same-cycle primary read and write to the same word returns whatever the macro returns.

## Timing
- Issue cycle N → SRAM captures at posedge N → done cycle N+1: busy 0, read data valid.
- Uncontended latency is 2 cycles for any access. A conflict loser is issued in N+1 and completes in N+2.
- Back-to-back: a client may present a new request in the cycle after its done cycle, giving 1 access per 2 cycles per client.
- Cross-bank primary write and secondary access issue in the same cycle and both complete in N+1.
- Reset (rst=1):
  - pDone, sDone and lastWinner are reset at the clock edge.
  - While rst is high, all combinational outputs are forced: csb0 and csb1 all 1, web0 all 1, wmask0/addr0/din0/addr1 0, read data all ones, busy 0.
- Reset mid-access: the pending access is abandoned with no completion. After rst falls, requests still held re-arbitrate from scratch.

## Test plan
- **Primary read.** Defaults; preload bank 1 word 3 = 0xDEADBEEF. Primary read at 0x00080C, byteSelect 0xF: cycle 0 csb1=4'b1101, addr1=3, pBusy=1; cycle 1 pBusy=0, pDataRead=0xDEADBEEF. With byteSelect 0x3 instead: pDataRead=0xFFFFBEEF.
- **Cross-bank concurrency.** Primary write 0x11223344 to bank 0 plus secondary write to bank 2, same cycle: csb0=4'b1010, both busy drop in cycle 1.
- **Same-bank conflicts.** Both clients write bank 1, repeated twice:
  - First conflict: primary wins and completes in cycle 1; secondary completes in cycle 2.
  - Next conflict: secondary wins.
- **Out-of-range.** Secondary write at 0x100000: sBusy=0, csb0 all 1, no SRAM write.
- **Reset mid-access.** Assert rst in the issue cycle: csb0 and csb1 all 1, busy 0 while rst is high. After release, the held request completes 2 cycles later.
- **Minimal configuration.** BLOCK_ADDRESS_SIZE=0, WORD_SIZE=64: write then read at byte address 0x18 returns the written value, with mask width 8.

Source files
------------

// File: rtl/local_memory_arbiter.sv
// local_memory_arbiter: arbitrates a core-side primary port and a bus-side
// secondary port onto a banked set of 1RW+1R SRAM macros. Primary reads use
// the R port of their bank; primary writes and all secondary accesses share
// the bank's RW port, with round-robin arbitration on same-bank conflicts.
module local_memory_arbiter #(
  parameter int ADDRESS_SIZE       = 24,
  parameter int WORD_SIZE          = 32,
  parameter int SRAM_ADDRESS_SIZE  = 9,
  parameter int BLOCK_ADDRESS_SIZE = 2,
  localparam int BYTES = WORD_SIZE / 8,
  localparam int BC    = 1 << BLOCK_ADDRESS_SIZE
) (
  input  logic                           clk,
  input  logic                           rst,

  // Primary (core load/store) client
  input  logic [ADDRESS_SIZE-1:0]        pAddress,
  input  logic [BYTES-1:0]               pByteSelect,
  input  logic                           pEnable,
  input  logic                           pWriteEnable,
  input  logic [WORD_SIZE-1:0]           pDataWrite,
  output logic [WORD_SIZE-1:0]           pDataRead,
  output logic                           pBusy,

  // Secondary (bus slave) client
  input  logic [ADDRESS_SIZE-1:0]        sAddress,
  input  logic [BYTES-1:0]               sByteSelect,
  input  logic                           sEnable,
  input  logic                           sWriteEnable,
  input  logic [WORD_SIZE-1:0]           sDataWrite,
  output logic [WORD_SIZE-1:0]           sDataRead,
  output logic                           sBusy,

  // SRAM macro clocks
  output logic                           clk0,
  output logic                           clk1,

  // Per-bank RW ports
  output logic [BC-1:0]                  csb0,
  output logic [BC-1:0]                  web0,
  output logic [BC*BYTES-1:0]            wmask0,
  output logic [BC*SRAM_ADDRESS_SIZE-1:0] addr0,
  output logic [BC*WORD_SIZE-1:0]        din0,
  input  logic [BC*WORD_SIZE-1:0]        dout0,

  // Per-bank R ports with a shared address
  output logic [BC-1:0]                  csb1,
  output logic [SRAM_ADDRESS_SIZE-1:0]   addr1,
  input  logic [BC*WORD_SIZE-1:0]        dout1
);

  // Byte offset bits below the word index, bank-index width (at least one
  // bit so the signal exists when there is a single bank), word-index width.
  localparam int OFS = $clog2(BYTES);
  localparam int BW  = (BLOCK_ADDRESS_SIZE > 0) ? BLOCK_ADDRESS_SIZE : 1;
  localparam int IW  = SRAM_ADDRESS_SIZE + BLOCK_ADDRESS_SIZE;

  // Which client won the most recent same-bank conflict.
  typedef enum logic {
    WIN_PRIMARY   = 1'b0,
    WIN_SECONDARY = 1'b1
  } winner_t;

  // Address decode
  logic [IW-1:0]                pIndex, sIndex;
  logic [SRAM_ADDRESS_SIZE-1:0] pWord, sWord;
  logic [BW-1:0]                pBank, sBank;
  logic                         pValid, sValid;

  // Byte-offset bits carry no information for word accesses; folding the
  // full buses here keeps every address bit accounted for.
  logic unusedAddressBits;
  assign unusedAddressBits = ^{pAddress, sAddress};

  assign pIndex = pAddress[IW+OFS-1:OFS];
  assign sIndex = sAddress[IW+OFS-1:OFS];
  assign pWord  = pIndex[SRAM_ADDRESS_SIZE-1:0];
  assign sWord  = sIndex[SRAM_ADDRESS_SIZE-1:0];

  // A request is valid only when every address bit above the word index is 0.
  assign pValid = pEnable && ((pAddress >> (IW + OFS)) == '0);
  assign sValid = sEnable && ((sAddress >> (IW + OFS)) == '0);

  generate
    if (BLOCK_ADDRESS_SIZE > 0) begin : gBankDecode
      assign pBank = pIndex[IW-1:SRAM_ADDRESS_SIZE];
      assign sBank = sIndex[IW-1:SRAM_ADDRESS_SIZE];
    end else begin : gSingleBank
      assign pBank = 1'b0;
      assign sBank = 1'b0;
    end
  endgenerate

  // Completion and arbitration state
  logic    pDone, sDone;
  winner_t lastWinner;

  // Datapath capture taken at issue, consumed in the done cycle
  logic [BW-1:0]    pBankReg, sBankReg;
  logic [BYTES-1:0] pSelReg, sSelReg;
  logic             pFromRw;

  // Issue decisions
  logic pReadIssue, pWriteEligible, sEligible, conflict;
  logic pWins, sWins, pIssue, sIssue;

  // Eligibility: a client whose done flag is up sits out that cycle, so a
  // held request never issues twice. Nothing issues while rst is high.
  assign pReadIssue     = !rst && pValid && !pWriteEnable && !pDone;
  assign pWriteEligible = !rst && pValid &&  pWriteEnable && !pDone;
  assign sEligible      = !rst && sValid && !sDone;

  // Each client targets a single bank, so at most one bank can see a conflict.
  assign conflict = pWriteEligible && sEligible && (pBank == sBank);

  // On a conflict the client that lost the previous conflict goes first.
  assign pWins  = pWriteEligible && (!conflict || (lastWinner == WIN_SECONDARY));
  assign sWins  = sEligible      && (!conflict || (lastWinner == WIN_PRIMARY));
  assign pIssue = pReadIssue || pWins;
  assign sIssue = sWins;

  // Busy until the done cycle; forced low during reset.
  assign pBusy = !rst && pValid && !pDone;
  assign sBusy = !rst && sValid && !sDone;

  // Macros are clocked straight from the arbiter clock.
  assign clk0 = clk;
  assign clk1 = clk;

  // Drive the RW port of each bank from its granted client, and the R port
  // of the bank hit by a primary read.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a bit unassigned and no latch is inferred.
    csb0   = '1;
    web0   = '1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    csb1   = '1;
    addr1  = '0;
    for (int b = 0; b < BC; b++) begin
      if (pWins && (pBank == BW'(b))) begin
        csb0[b]                                        = 1'b0;
        web0[b]                                        = 1'b0;
        wmask0[b*BYTES +: BYTES]                       = pByteSelect;
        addr0[b*SRAM_ADDRESS_SIZE +: SRAM_ADDRESS_SIZE] = pWord;
        din0[b*WORD_SIZE +: WORD_SIZE]                 = pDataWrite;
      end else if (sWins && (sBank == BW'(b))) begin
        csb0[b]                                        = 1'b0;
        web0[b]                                        = !sWriteEnable;
        wmask0[b*BYTES +: BYTES]                       = sByteSelect;
        addr0[b*SRAM_ADDRESS_SIZE +: SRAM_ADDRESS_SIZE] = sWord;
        din0[b*WORD_SIZE +: WORD_SIZE]                 = sDataWrite;
      end
      if (pReadIssue && (pBank == BW'(b))) begin
        csb1[b] = 1'b0;
      end
    end
    if (pReadIssue) begin
      addr1 = pWord;
    end
  end

  // Done flags pulse for one cycle after issue; lastWinner moves only on a conflict.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pDone      <= 1'b0;
      sDone      <= 1'b0;
      lastWinner <= WIN_SECONDARY;
    end else begin
      pDone <= pIssue;
      sDone <= sIssue;
      if (conflict) begin
        lastWinner <= pWins ? WIN_PRIMARY : WIN_SECONDARY;
      end
    end
  end

  // Capture bank, byte select and source port of each issued access.
  always_ff @(posedge clk) begin
    // NOTE: these capture registers are left unreset on purpose; they are
    // only read while a done flag is set, and done flags are reset.
    if (pIssue) begin
      pBankReg <= pBank;
      pSelReg  <= pByteSelect;
      pFromRw  <= pWriteEnable;
    end
    if (sIssue) begin
      sBankReg <= sBank;
      sSelReg  <= sByteSelect;
    end
  end

  // Return masked macro data in the done cycle, all ones otherwise.
  always_comb begin
    logic [WORD_SIZE-1:0] pSrc;
    logic [WORD_SIZE-1:0] sSrc;
    pSrc      = '0;
    sSrc      = '0;
    pDataRead = '1;
    sDataRead = '1;
    for (int b = 0; b < BC; b++) begin
      if (pBankReg == BW'(b)) begin
        pSrc = pFromRw ? dout0[b*WORD_SIZE +: WORD_SIZE] : dout1[b*WORD_SIZE +: WORD_SIZE];
      end
      if (sBankReg == BW'(b)) begin
        sSrc = dout0[b*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (pDone && !rst) begin
      for (int i = 0; i < BYTES; i++) begin
        if (pSelReg[i]) begin
          pDataRead[i*8 +: 8] = pSrc[i*8 +: 8];
        end
      end
    end
    if (sDone && !rst) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sSelReg[i]) begin
          sDataRead[i*8 +: 8] = sSrc[i*8 +: 8];
        end
      end
    end
  end

endmodule
